ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage RISC-V pipeline: holds the ID/EX pipeline register, applies the 2-bit operand-forwarding selects produced by the forwarding unit, runs the ALU, and loads the EX/MEM pipeline register. It also flags load-use hazards back to decode. It sits between the decode stage and the memory stage.

## Interface
- XLEN, 32, datapath width
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  global freeze; both pipeline registers hold
- flush  in  1  load a bubble into ID/EX
- id_valid  in  1  decode slot holds a real instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_op  in  4  ALU operation
- id_alu_src  in  1  selects operand B: 1 = immediate, 0 = forwarded rs2
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- fwd_a, fwd_b  in  2 each  forwarding selects: 00 = register file, 01 = WB, 10 = MEM, 11 = register file
- wb_fwd_data  in  XLEN  write-back result
- ex_rs1, ex_rs2  out  5 each  ID/EX source indices, sent to the forwarding unit
- ex_rd_out  out  5  ID/EX destination index
- load_use_hazard  out  1  combinational stall request to decode
- exm_valid, exm_reg_write, exm_mem_read, exm_mem_write  out  1 each  EX/MEM control
- exm_rd  out  5  EX/MEM destination index
- exm_alu_result  out  XLEN  ALU result; also the MEM forwarding source
- exm_store_data  out  XLEN  forwarded rs2 value for stores

## Operation
- **ID/EX register.** Captures all `id_*` fields on each clock unless held or flushed.
- **Operand A.** `fwd_a` picks from `ex_rs1_data`, `wb_fwd_data`, or `exm_alu_result`. The MEM source is this block's own EX/MEM register.
- **Forwarded B.** `fwd_b` picks between the same three sources, using `ex_rs2_data` as the register-file source.
- **Operand B.** Operand B = `ex_alu_src` ? `ex_imm` : forwarded B.
- **Store data.** `exm_store_data` always takes forwarded B, never the immediate.
- **ALU ops** (`id_alu_op`):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[4:0]
  - 8 SLT (signed), 9 SLTU; result is 1 or 0, zero-extended
  - 10 PASSB
  - codes 11–15 produce result 0
- **Arithmetic width.** ADD and SUB wrap modulo 2^XLEN; no flags.
- **Load-use hazard.** `load_use_hazard` = `ex_mem_read` & `ex_valid` & (`ex_rd` != 0) & (`ex_rd` == `id_rs1` | `ex_rd` == `id_rs2`). Decode answers by stalling IF/ID and asserting `flush` for one cycle.
- **Bubble.** A bubble in either register has valid, reg_write, mem_read and mem_write = 0. The index and data fields of a bubble are don't-care.

## Timing
- **Reset** (synchronous `rst` = 1): both registers become bubbles.
  - All `ex*`/`exm_*` outputs = 0.
  - `load_use_hazard` = 0.
  - Reset overrides `stall` and `flush`.
- **Latency.** An instruction presented on `id_*` at edge N appears on `ex_*` after N. Its result is on `exm_*` after N+1.
- **Priority** per edge: `rst` > `stall` > `flush` > normal load.
  - `stall` = 1: both registers hold, even if `flush` = 1. Decode must hold `flush` until a non-stalled edge.
  - `flush` = 1, `stall` = 0: ID/EX loads a bubble, and EX/MEM loads the instruction leaving EX.
- **Forwarding during stall.** `fwd_*` and `wb_fwd_data` are sampled combinationally each cycle. The value captured into EX/MEM is the one present at the capturing edge.
- **Hazard during stall.** `load_use_hazard` updates combinationally, including during `stall`.
- **Reset mid-operation.** In-flight instructions are discarded; there is no replay.

## Structure
- Package `ex_pkg`:
  - ALU opcode localparams
  - forwarding-select constants `FWD_RF` = 2'b00, `FWD_WB` = 2'b01, `FWD_MEM` = 2'b10
- Sub-module `alu`: purely combinational. Ports: `op`, `a`, `b`, `result`.
- Registers and the forwarding muxes stay in `ex_stage`.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `id_valid` = 1 and `id_reg_write` = 1 driven → `exm_valid` = 0, `exm_reg_write` = 0, `exm_alu_result` = 0.
- **Basic ADD, no forwarding.** ADD with rs1_data = 5, rs2_data = 7, `fwd` = 00 → `exm_alu_result` = 12, two edges later. Repeat with SUB on 0 − 1 → 0xFFFFFFFF.
- **MEM forwarding.** Back-to-back ADD x1 = 3 + 4, then ADD x2 = x1 + x1 with `fwd_a` = `fwd_b` = 10 → second result = 14. Also `fwd_a` = 01 with `wb_fwd_data` = 100, B = imm 1 → 101.
- **Load-use hazard.** Load in ID/EX with rd = 3 while `id_rs2` = 3 → `load_use_hazard` = 1. Same case with rd = 0 → 0. Then `flush` for one cycle → the following EX/MEM entry is a bubble (`exm_valid` = 0).
- **Stall vs flush.** Assert `stall` and `flush` together for 3 cycles → `exm_*` unchanged throughout. On release with `flush` still high → ID/EX bubble.
- **ALU edge cases.**
  - SRA 0x80000000 by 4 → 0xF8000000
  - SLT(−1, 1) → 1; SLTU(−1, 1) → 0
  - op 13 → 0
  - `fwd` select 11 → register-file value used

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: ALU opcodes and forwarding selects.
package ex_pkg;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_SLL   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_SLT   = 4'd8;
   localparam logic [3:0] ALU_SLTU  = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational RV32 ALU; unused opcodes yield zero.
module alu
   import ex_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result
);

   logic signed [XLEN-1:0] w_a_s;
   logic signed [XLEN-1:0] w_b_s;
   logic        [4:0]      w_shamt;

   assign w_a_s   = a;
   assign w_b_s   = b;
   assign w_shamt = b[4:0];

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = a - b;
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_XOR:   result = a ^ b;
         ALU_SLL:   result = a << w_shamt;
         ALU_SRL:   result = a >> w_shamt;
         ALU_SRA:   result = w_a_s >>> w_shamt;
         ALU_SLT:   result = {{(XLEN-1){1'b0}}, (w_a_s < w_b_s)};
         ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_PASSB: result = b;
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, EX/MEM register,
// and load-use hazard detection toward decode.
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [3:0]      id_alu_op,
   input  logic            id_alu_src,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic [1:0]      fwd_a,
   input  logic [1:0]      fwd_b,
   input  logic [XLEN-1:0] wb_fwd_data,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd_out,
   output logic            load_use_hazard,
   output logic            exm_valid,
   output logic            exm_reg_write,
   output logic            exm_mem_read,
   output logic            exm_mem_write,
   output logic [4:0]      exm_rd,
   output logic [XLEN-1:0] exm_alu_result,
   output logic [XLEN-1:0] exm_store_data
);

   // ID/EX stage (p0)
   logic            r_vld_p0, r_reg_write_p0, r_mem_read_p0, r_mem_write_p0;
   logic [4:0]      r_rs1_p0, r_rs2_p0, r_rd_p0;
   logic [XLEN-1:0] r_rs1_data_p0, r_rs2_data_p0, r_imm_p0;
   logic [3:0]      r_alu_op_p0;
   logic            r_alu_src_p0;

   // EX/MEM stage (p1)
   logic            r_vld_p1, r_reg_write_p1, r_mem_read_p1, r_mem_write_p1;
   logic [4:0]      r_rd_p1;
   logic [XLEN-1:0] r_alu_result_p1, r_store_data_p1;

   logic [XLEN-1:0] w_opa, w_fwd_b, w_opb, w_alu_result;

   always_comb begin
      w_opa = r_rs1_data_p0;
      case (fwd_a)
         FWD_WB:  w_opa = wb_fwd_data;
         FWD_MEM: w_opa = r_alu_result_p1;
         default: w_opa = r_rs1_data_p0;
      endcase
   end

   always_comb begin
      w_fwd_b = r_rs2_data_p0;
      case (fwd_b)
         FWD_WB:  w_fwd_b = wb_fwd_data;
         FWD_MEM: w_fwd_b = r_alu_result_p1;
         default: w_fwd_b = r_rs2_data_p0;
      endcase
   end

   assign w_opb = r_alu_src_p0 ? r_imm_p0 : w_fwd_b;

   alu #(.XLEN(XLEN)) u_alu (
      .op     (r_alu_op_p0),
      .a      (w_opa),
      .b      (w_opb),
      .result (w_alu_result)
   );

   assign load_use_hazard = r_mem_read_p0 & r_vld_p0 & (r_rd_p0 != 5'd0) &
                            ((r_rd_p0 == id_rs1) | (r_rd_p0 == id_rs2));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p0        <= 1'b0;
         r_reg_write_p0  <= 1'b0;
         r_mem_read_p0   <= 1'b0;
         r_mem_write_p0  <= 1'b0;
         r_rs1_p0        <= '0;
         r_rs2_p0        <= '0;
         r_rd_p0         <= '0;
         r_rs1_data_p0   <= '0;
         r_rs2_data_p0   <= '0;
         r_imm_p0        <= '0;
         r_alu_op_p0     <= '0;
         r_alu_src_p0    <= 1'b0;
         r_vld_p1        <= 1'b0;
         r_reg_write_p1  <= 1'b0;
         r_mem_read_p1   <= 1'b0;
         r_mem_write_p1  <= 1'b0;
         r_rd_p1         <= '0;
         r_alu_result_p1 <= '0;
         r_store_data_p1 <= '0;
      end else if (!stall) begin
         r_vld_p1        <= r_vld_p0;
         r_reg_write_p1  <= r_reg_write_p0;
         r_mem_read_p1   <= r_mem_read_p0;
         r_mem_write_p1  <= r_mem_write_p0;
         r_rd_p1         <= r_rd_p0;
         r_alu_result_p1 <= w_alu_result;
         r_store_data_p1 <= w_fwd_b;
         // A flush turns the incoming slot into an all-zero bubble.
         r_vld_p0        <= flush ? 1'b0 : id_valid;
         r_reg_write_p0  <= flush ? 1'b0 : id_reg_write;
         r_mem_read_p0   <= flush ? 1'b0 : id_mem_read;
         r_mem_write_p0  <= flush ? 1'b0 : id_mem_write;
         r_rs1_p0        <= flush ? '0 : id_rs1;
         r_rs2_p0        <= flush ? '0 : id_rs2;
         r_rd_p0         <= flush ? '0 : id_rd;
         r_rs1_data_p0   <= flush ? '0 : id_rs1_data;
         r_rs2_data_p0   <= flush ? '0 : id_rs2_data;
         r_imm_p0        <= flush ? '0 : id_imm;
         r_alu_op_p0     <= flush ? '0 : id_alu_op;
         r_alu_src_p0    <= flush ? 1'b0 : id_alu_src;
      end
   end

   assign ex_rs1         = r_rs1_p0;
   assign ex_rs2         = r_rs2_p0;
   assign ex_rd_out      = r_rd_p0;
   assign exm_valid      = r_vld_p1;
   assign exm_reg_write  = r_reg_write_p1;
   assign exm_mem_read   = r_mem_read_p1;
   assign exm_mem_write  = r_mem_write_p1;
   assign exm_rd         = r_rd_p1;
   assign exm_alu_result = r_alu_result_p1;
   assign exm_store_data = r_store_data_p1;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized traffic
// against a transaction-level model of the two pipeline slots.
module tb_ex_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, flush, id_valid, id_alu_src;
   logic        id_reg_write, id_mem_read, id_mem_write;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm, wb_fwd_data;
   logic [3:0]  id_alu_op;
   logic [1:0]  fwd_a, fwd_b;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd_out, exm_rd;
   logic        load_use_hazard, exm_valid, exm_reg_write, exm_mem_read, exm_mem_write;
   logic [31:0] exm_alu_result, exm_store_data;

   ex_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_fwd_data(wb_fwd_data),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd_out(ex_rd_out),
      .load_use_hazard(load_use_hazard),
      .exm_valid(exm_valid), .exm_reg_write(exm_reg_write),
      .exm_mem_read(exm_mem_read), .exm_mem_write(exm_mem_write),
      .exm_rd(exm_rd), .exm_alu_result(exm_alu_result), .exm_store_data(exm_store_data)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: one record per pipeline slot
   typedef struct packed {
      logic        v, rw, mr, mw;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm;
      logic [3:0]  op;
      logic        src;
   } idex_t;
   typedef struct packed {
      logic        v, rw, mr, mw;
      logic [4:0]  rd;
      logic [31:0] res, st;
   } exm_t;

   idex_t m_ex;
   exm_t  m_exm;
   logic [31:0] m_a, m_fb;

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = b % 32;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return a << sh;
         4'd6:  return a >> sh;
         4'd7:  return 32'($signed(a) >>> sh);
         4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:  return (a < b) ? 32'd1 : 32'd0;
         4'd10: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] wb, input logic [31:0] mem);
      if (sel == 2'b01) return wb;
      if (sel == 2'b10) return mem;
      return rf;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_ex  = '0;
         m_exm = '0;
      end else if (!stall) begin
         m_a  = pick(fwd_a, m_ex.d1, wb_fwd_data, m_exm.res);
         m_fb = pick(fwd_b, m_ex.d2, wb_fwd_data, m_exm.res);
         m_exm.v   = m_ex.v;
         m_exm.rw  = m_ex.rw;
         m_exm.mr  = m_ex.mr;
         m_exm.mw  = m_ex.mw;
         m_exm.rd  = m_ex.rd;
         m_exm.res = alu_ref(m_ex.op, m_a, m_ex.src ? m_ex.imm : m_fb);
         m_exm.st  = m_fb;
         if (flush) m_ex = '0;
         else m_ex = '{v: id_valid, rw: id_reg_write, mr: id_mem_read, mw: id_mem_write,
                       rs1: id_rs1, rs2: id_rs2, rd: id_rd, d1: id_rs1_data, d2: id_rs2_data,
                       imm: id_imm, op: id_alu_op, src: id_alu_src};
      end
   end

   // Compare every cycle on the falling edge; index/data fields only for real slots
   always @(negedge clk) begin
      chk("hazard", 32'(load_use_hazard),
          32'(m_ex.mr & m_ex.v & (m_ex.rd != 0) & ((m_ex.rd == id_rs1) | (m_ex.rd == id_rs2))));
      chk("exm_valid", 32'(exm_valid), 32'(m_exm.v));
      chk("exm_reg_write", 32'(exm_reg_write), 32'(m_exm.rw));
      chk("exm_mem_read", 32'(exm_mem_read), 32'(m_exm.mr));
      chk("exm_mem_write", 32'(exm_mem_write), 32'(m_exm.mw));
      if (m_ex.v) begin
         chk("ex_rs1", 32'(ex_rs1), 32'(m_ex.rs1));
         chk("ex_rs2", 32'(ex_rs2), 32'(m_ex.rs2));
         chk("ex_rd_out", 32'(ex_rd_out), 32'(m_ex.rd));
      end
      if (m_exm.v) begin
         chk("exm_rd", 32'(exm_rd), 32'(m_exm.rd));
         chk("exm_alu_result", exm_alu_result, m_exm.res);
         chk("exm_store_data", exm_store_data, m_exm.st);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [3:0] op, input logic src, input logic rw, input logic mr, input logic mw);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
      id_alu_op = op; id_alu_src = src;
      id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
   endtask

   task automatic bubble_id();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // One instruction through EX with the given forwarding applied while it is in EX
   task automatic run_one(input string nm, input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic src, input logic [1:0] fa, input logic [1:0] fb,
                          input logic [31:0] wb, input logic [31:0] exp);
      set_id(1'b1, 5'd1, 5'd2, 5'd7, d1, d2, imm, op, src, 1'b1, 1'b0, 1'b0);
      fwd_a = 2'b00; fwd_b = 2'b00;
      step();
      fwd_a = fa; fwd_b = fb; wb_fwd_data = wb;
      bubble_id();
      step();
      chk(nm, exm_alu_result, exp);
      fwd_a = 2'b00; fwd_b = 2'b00;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      fwd_a = 2'b00; fwd_b = 2'b00; wb_fwd_data = 32'd0;
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(); step();
      chk("reset_exm_valid", 32'(exm_valid), 32'd0);
      chk("reset_exm_reg_write", 32'(exm_reg_write), 32'd0);
      chk("reset_exm_alu_result", exm_alu_result, 32'd0);
      chk("reset_hazard", 32'(load_use_hazard), 32'd0);
      rst = 1'b0;
      bubble_id();
      step();

      run_one("add_5_7", 4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd12);
      run_one("sub_0_1", 4'd1, 32'd0, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'hFFFF_FFFF);

      // Back-to-back dependency through the MEM forwarding path
      set_id(1'b1, 5'd0, 5'd0, 5'd1, 32'd3, 32'd4, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      set_id(1'b1, 5'd1, 5'd1, 5'd2, 32'd99, 32'd99, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      chk("mem_fwd_first", exm_alu_result, 32'd7);
      fwd_a = 2'b10; fwd_b = 2'b10;
      bubble_id();
      step();
      chk("mem_fwd_second", exm_alu_result, 32'd14);
      chk("mem_fwd_store", exm_store_data, 32'd7);
      fwd_a = 2'b00; fwd_b = 2'b00;
      run_one("wb_fwd_imm", 4'd0, 32'd55, 32'd0, 32'd1, 1'b1, 2'b01, 2'b00, 32'd100, 32'd101);

      // Load-use hazard and the decode-driven flush
      set_id(1'b1, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'd8, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd9, 5'd3, 5'd4, 32'd1, 32'd2, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("luh_rd3", 32'(load_use_hazard), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("luh_after_flush", 32'(load_use_hazard), 32'd0);
      chk("load_in_exm", 32'(exm_mem_read), 32'd1);
      step();
      chk("flush_bubble", 32'(exm_valid), 32'd0);
      set_id(1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd0, 5'd0, 5'd5, 32'd1, 32'd2, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("luh_rd0", 32'(load_use_hazard), 32'd0);

      // Stall overrides flush; results hold
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'd20, 32'd22, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      set_id(1'b1, 5'd1, 5'd2, 5'd6, 32'd1, 32'd1, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      stall = 1'b1; flush = 1'b1;
      set_id(1'b1, 5'd3, 5'd4, 5'd8, 32'd500, 32'd600, 32'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         fwd_a = 2'($urandom_range(0, 3)); wb_fwd_data = $urandom;
         step();
         chk("stall_exm_result", exm_alu_result, 32'd42);
         chk("stall_exm_rd", 32'(exm_rd), 32'd5);
         chk("stall_ex_rd", 32'(ex_rd_out), 32'd6);
      end
      stall = 1'b0; fwd_a = 2'b00;
      step();
      chk("release_exm_result", exm_alu_result, 32'd2);
      flush = 1'b0;
      bubble_id();
      step();
      chk("release_idex_bubble", 32'(exm_valid), 32'd0);

      run_one("sra", 4'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 2'b00, 2'b00, 32'd0, 32'hF800_0000);
      run_one("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd1);
      run_one("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
      run_one("op13", 4'd13, 32'd5, 32'd6, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
      run_one("fwd_11", 4'd0, 32'd10, 32'd5, 32'd0, 1'b0, 2'b11, 2'b11, 32'd777, 32'd15);

      // Randomized traffic checked by the per-cycle compare
      for (int n = 0; n < 500; n++) begin
         rst   = ($urandom_range(0, 99) == 0);
         stall = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 7) == 0);
         set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         if (($urandom_range(0, 3) == 0) && n > 0) id_rs1_data = 32'h8000_0000 | id_rs1_data;
         wb_fwd_data = $urandom;
         fwd_a = 2'($urandom_range(0, 3));
         fwd_b = 2'($urandom_range(0, 3));
         if (!m_exm.v && fwd_a == 2'b10) fwd_a = 2'b00;
         if (!m_exm.v && fwd_b == 2'b10) fwd_b = 2'b00;
         step();
      end
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
